// File: rtl/insn_encoder_pkg.sv
// Shared instruction-field definitions for the encoder path: widths, field
// positions, opecode class patterns, skid-buffer state encoding and payload.
package insn_encoder_pkg;

    localparam int unsigned LEN_INSN     = 32;
    localparam int unsigned LEN_OPECODE  = 7;
    localparam int unsigned LEN_IMMF     = 1;
    localparam int unsigned LEN_REGNO    = 5;
    localparam int unsigned LEN_CC       = 4;
    localparam int unsigned LEN_IMM      = 16;
    localparam int unsigned LEN_IMM_EX   = 32;
    localparam int unsigned LEN_SHAMT    = 5;
    localparam int unsigned LEN_CLASS_HI = 4;

    // LSB of each field; rs/cc and imm overlap and are selected by immf
    localparam int unsigned SHIFT_OPECODE = 25;
    localparam int unsigned SHIFT_IMMF    = 24;
    localparam int unsigned SHIFT_RD      = 19;
    localparam int unsigned SHIFT_RS      = 14;
    localparam int unsigned SHIFT_CC      = 10;
    localparam int unsigned SHIFT_IMM     = 0;

    // Opecode class patterns, matched on the top four opecode bits
    localparam logic [LEN_CLASS_HI-1:0] OPC_HI_SIGNED0 = 4'b0000; // 000_0xxx
    localparam logic [LEN_CLASS_HI-1:0] OPC_HI_SHAMT   = 4'b0001; // 000_1xxx
    localparam logic [LEN_CLASS_HI-1:0] OPC_HI_SIGNED1 = 4'b0011; // 001_1xxx

    typedef enum logic [1:0] {
        CLASS_UNSIGNED = 2'd0,
        CLASS_SIGNED   = 2'd1,
        CLASS_SHAMT    = 2'd2
    } imm_class_e;

    typedef enum logic [1:0] {
        ST_EMPTY = 2'd0,
        ST_ONE   = 2'd1,
        ST_FULL  = 2'd2
    } skid_state_e;

    typedef struct packed {
        logic                err;
        logic [LEN_INSN-1:0] insn;
    } enc_word_t;

    // Immediate class of an opecode
    function automatic imm_class_e opc_class(input logic [LEN_OPECODE-1:0] opc);
        case (opc[LEN_OPECODE-1 -: LEN_CLASS_HI])
            OPC_HI_SIGNED0, OPC_HI_SIGNED1: return CLASS_SIGNED;
            OPC_HI_SHAMT:                   return CLASS_SHAMT;
            default:                        return CLASS_UNSIGNED;
        endcase
    endfunction

endpackage

// File: rtl/insn_skid_buf.sv
// Two-entry output/skid buffer with valid/stall handshake; stall_o is a flop.
module insn_skid_buf
    import insn_encoder_pkg::*;
#(
    parameter int unsigned WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             valid_i,
    output logic             stall_o,
    input  logic [WIDTH-1:0] data_i,
    output logic             valid_o,
    input  logic             stall_i,
    output logic [WIDTH-1:0] data_o
);

    skid_state_e      state_q, state_d;
    logic [WIDTH-1:0] out_q, skid_q;
    logic             valid_q, stall_q;
    logic             accept_c;
    logic             load_out_in_c, load_out_skid_c, load_skid_c;

    // Next-state and register-load decisions
    always_comb begin
        state_d         = state_q;
        load_out_in_c   = 1'b0;
        load_out_skid_c = 1'b0;
        load_skid_c     = 1'b0;
        accept_c        = valid_i & ~stall_q;
        case (state_q)
            ST_EMPTY: begin
                if (accept_c) begin
                    load_out_in_c = 1'b1;
                    state_d       = ST_ONE;
                end
            end
            ST_ONE: begin
                if (accept_c) begin
                    if (stall_i) begin
                        load_skid_c = 1'b1;
                        state_d     = ST_FULL;
                    end else begin
                        load_out_in_c = 1'b1;
                    end
                end else if (!stall_i) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (!stall_i) begin
                    load_out_skid_c = 1'b1;
                    state_d         = ST_ONE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    // State, handshake flags and data registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= ST_EMPTY;
            valid_q <= 1'b0;
            stall_q <= 1'b0;
            out_q   <= '0;
            skid_q  <= '0;
        end else begin
            state_q <= state_d;
            valid_q <= (state_d != ST_EMPTY);
            stall_q <= (state_d == ST_FULL);
            if (load_out_in_c) begin
                out_q <= data_i;
            end else if (load_out_skid_c) begin
                out_q <= skid_q;
            end
            if (load_skid_c) begin
                skid_q <= data_i;
            end
        end
    end

    assign valid_o = valid_q;
    assign stall_o = stall_q;
    assign data_o  = out_q;

endmodule

// File: rtl/insn_encoder.sv
// Packs decoded instruction fields into an instruction word behind a skid buffer.
// Define INSN_ENCODER_RANGE_CHECK_EN to compile in the immediate range check (err_o).
module insn_encoder
    import insn_encoder_pkg::*;
(
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   valid_i,
    output logic                   stall_o,
    output logic                   valid_o,
    input  logic                   stall_i,
    input  logic [LEN_OPECODE-1:0] opecode_i,
    input  logic [LEN_IMMF-1:0]    immf_i,
    input  logic [LEN_REGNO-1:0]   rd_i,
    input  logic [LEN_REGNO-1:0]   rs_i,
    input  logic [LEN_CC-1:0]      cc_i,
    input  logic [LEN_IMM_EX-1:0]  imm_ex_i,
    output logic [LEN_INSN-1:0]    insn_o,
    output logic                   err_o
);

    imm_class_e          cls_c;
    logic [LEN_IMM-1:0]  imm_field_c;
    logic [LEN_INSN-1:0] word_c;

    // Field packing; shift amounts keep only their low bits
    always_comb begin
        cls_c       = opc_class(opecode_i);
        imm_field_c = imm_ex_i[LEN_IMM-1:0];
        if (cls_c == CLASS_SHAMT) begin
            imm_field_c = LEN_IMM'(imm_ex_i[LEN_SHAMT-1:0]);
        end
        word_c = '0;
        word_c[SHIFT_OPECODE +: LEN_OPECODE] = opecode_i;
        word_c[SHIFT_IMMF +: LEN_IMMF]       = immf_i;
        word_c[SHIFT_RD +: LEN_REGNO]        = rd_i;
        if (immf_i == 1'b0) begin
            word_c[SHIFT_RS +: LEN_REGNO] = rs_i;
            word_c[SHIFT_CC +: LEN_CC]    = cc_i;
        end else begin
            word_c[SHIFT_IMM +: LEN_IMM] = imm_field_c;
        end
    end

`ifdef INSN_ENCODER_RANGE_CHECK_EN
    logic [LEN_IMM_EX-LEN_IMM:0] sign_bits_c;
    logic                        fits_c;
    enc_word_t                   pay_in_c, pay_out;

    // Representability of the extended immediate for the opecode class
    always_comb begin
        sign_bits_c = imm_ex_i[LEN_IMM_EX-1:LEN_IMM-1];
        case (cls_c)
            CLASS_SIGNED: fits_c = (&sign_bits_c) | ~(|sign_bits_c);
            CLASS_SHAMT:  fits_c = ~(|imm_ex_i[LEN_IMM_EX-1:LEN_SHAMT]);
            default:      fits_c = ~(|imm_ex_i[LEN_IMM_EX-1:LEN_IMM]);
        endcase
        pay_in_c.err  = immf_i[0] & ~fits_c;
        pay_in_c.insn = word_c;
    end

    insn_skid_buf #(
        .WIDTH ($bits(enc_word_t))
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .stall_o (stall_o),
        .data_i  (pay_in_c),
        .valid_o (valid_o),
        .stall_i (stall_i),
        .data_o  (pay_out)
    );

    assign insn_o = pay_out.insn;
    assign err_o  = pay_out.err;
`else
    logic unused_imm_hi;

    insn_skid_buf #(
        .WIDTH (LEN_INSN)
    ) u_skid (
        .clk     (clk),
        .rst     (rst),
        .valid_i (valid_i),
        .stall_o (stall_o),
        .data_i  (word_c),
        .valid_o (valid_o),
        .stall_i (stall_i),
        .data_o  (insn_o)
    );

    // Upper immediate bits only matter to the range check
    assign unused_imm_hi = ^imm_ex_i[LEN_IMM_EX-1:LEN_IMM];
    assign err_o         = 1'b0;
`endif

endmodule

// File: tb/tb_insn_encoder.sv
// Directed self-checking bench for insn_encoder.
module tb_insn_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        valid_i;
    logic        stall_o;
    logic        valid_o;
    logic        stall_i;
    logic [6:0]  opecode_i;
    logic [0:0]  immf_i;
    logic [4:0]  rd_i;
    logic [4:0]  rs_i;
    logic [3:0]  cc_i;
    logic [31:0] imm_ex_i;
    logic [31:0] insn_o;
    logic        err_o;

    int tests = 0;
    int fails = 0;

    logic [31:0] words [0:3];

`ifdef INSN_ENCODER_RANGE_CHECK_EN
    localparam logic CHK = 1'b1;
`else
    localparam logic CHK = 1'b0;
`endif

    always #5 clk = ~clk;

    insn_encoder dut (
        .clk       (clk),
        .rst       (rst),
        .valid_i   (valid_i),
        .stall_o   (stall_o),
        .valid_o   (valid_o),
        .stall_i   (stall_i),
        .opecode_i (opecode_i),
        .immf_i    (immf_i),
        .rd_i      (rd_i),
        .rs_i      (rs_i),
        .cc_i      (cc_i),
        .imm_ex_i  (imm_ex_i),
        .insn_o    (insn_o),
        .err_o     (err_o)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [6:0] opc, input logic immf,
                         input logic [4:0] rd, input logic [4:0] rs,
                         input logic [3:0] cc, input logic [31:0] imm);
        valid_i   = v;
        opecode_i = opc;
        immf_i    = immf;
        rd_i      = rd;
        rs_i      = rs;
        cc_i      = cc;
        imm_ex_i  = imm;
    endtask

    task automatic test_reset();
        rst     = 1'b1;
        stall_i = 1'b0;
        drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
        step();
        step();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL reset valid_o: got %b want 0", valid_o); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL reset stall_o: got %b want 0", stall_o); end
        tests++; if (insn_o !== 32'h0) begin fails++; $display("FAIL reset insn_o: got %h want 00000000", insn_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL reset err_o: got %b want 0", err_o); end
        rst = 1'b0;
    endtask

    task automatic test_pack();
        logic [6:0]  v_opc  [0:9];
        logic        v_immf [0:9];
        logic [4:0]  v_rd   [0:9];
        logic [4:0]  v_rs   [0:9];
        logic [3:0]  v_cc   [0:9];
        logic [31:0] v_imm  [0:9];
        logic [31:0] v_word [0:9];
        logic        v_err  [0:9];
        v_opc  = '{7'h01, 7'h01, 7'h0A, 7'h0A, 7'h20, 7'h18, 7'h18, 7'h20, 7'h20, 7'h0A};
        v_immf = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
        v_rd   = '{5'd3, 5'd0, 5'd0, 5'd0, 5'd1, 5'd0, 5'd0, 5'd0, 5'd0, 5'd2};
        v_rs   = '{5'd0, 5'd0, 5'd0, 5'd0, 5'd7, 5'd0, 5'd0, 5'd0, 5'd0, 5'd3};
        v_cc   = '{4'h0, 4'h0, 4'h0, 4'h0, 4'hA, 4'h0, 4'h0, 4'h0, 4'h0, 4'h1};
        v_imm  = '{32'hFFFF_FFFE, 32'h0001_0000, 32'h0000_0020, 32'h0000_001F, 32'hDEAD_BEEF,
                   32'hFFFF_8000, 32'h0000_8000, 32'h0000_FFFF, 32'h0001_FFFF, 32'hFFFF_FFFF};
        v_word = '{32'h0318_FFFE, 32'h0300_0000, 32'h1500_0000, 32'h1500_001F, 32'h4009_E800,
                   32'h3100_8000, 32'h3100_8000, 32'h4100_FFFF, 32'h4100_FFFF, 32'h1410_C400};
        v_err  = '{1'b0, CHK, CHK, 1'b0, 1'b0, 1'b0, CHK, 1'b0, CHK, 1'b0};
        stall_i = 1'b0;
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, v_opc[i], v_immf[i], v_rd[i], v_rs[i], v_cc[i], v_imm[i]);
            step();
            tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL pack[%0d] valid_o: got %b want 1", i, valid_o); end
            tests++; if (insn_o !== v_word[i]) begin fails++; $display("FAIL pack[%0d] insn_o: got %h want %h", i, insn_o, v_word[i]); end
            tests++; if (err_o !== v_err[i]) begin fails++; $display("FAIL pack[%0d] err_o: got %b want %b", i, err_o, v_err[i]); end
            drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
            step();
            tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL pack[%0d] drain valid_o: got %b want 0", i, valid_o); end
        end
    endtask

    task automatic test_back_to_back();
        stall_i = 1'b0;
        for (int k = 0; k < 5; k++) begin
            if (k > 0) begin
                tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL b2b[%0d] valid_o: got %b want 1", k, valid_o); end
                tests++; if (insn_o !== words[k-1]) begin fails++; $display("FAIL b2b[%0d] insn_o: got %h want %h", k, insn_o, words[k-1]); end
            end
            tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL b2b[%0d] stall_o: got %b want 0", k, stall_o); end
            if (k < 4) drive(1'b1, 7'h20, 1'b0, 5'(k), 5'd0, 4'h0, 32'h0);
            else       drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
            step();
        end
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL b2b end valid_o: got %b want 0", valid_o); end
    endtask

    task automatic test_stall_stream();
        logic [8:0] exp_stall = 9'h01C;
        logic [8:0] exp_valid = 9'h0FE;
        int in_idx = 0;
        int out_idx = 0;
        int acc_cyc [0:3] = '{-1, -1, -1, -1};
        int emit_cyc [0:3] = '{-1, -1, -1, -1};
        int exp_acc [0:3] = '{0, 1, 5, 6};
        int exp_emit [0:3] = '{4, 5, 6, 7};
        for (int c = 0; c < 20; c++) begin
            stall_i = (c >= 1 && c <= 3);
            if (in_idx < 4) drive(1'b1, 7'h20, 1'b0, 5'(in_idx), 5'd0, 4'h0, 32'h0);
            else            drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
            if (c <= 8) begin
                tests++; if (stall_o !== exp_stall[c]) begin fails++; $display("FAIL stream c%0d stall_o: got %b want %b", c, stall_o, exp_stall[c]); end
                tests++; if (valid_o !== exp_valid[c]) begin fails++; $display("FAIL stream c%0d valid_o: got %b want %b", c, valid_o, exp_valid[c]); end
            end
            if (c >= 1 && c <= 3) begin
                tests++; if (insn_o !== words[0]) begin fails++; $display("FAIL stream c%0d hold insn_o: got %h want %h", c, insn_o, words[0]); end
            end
            if (valid_o === 1'b1 && stall_i === 1'b0) begin
                if (out_idx < 4) begin
                    tests++; if (insn_o !== words[out_idx]) begin fails++; $display("FAIL stream out%0d insn_o: got %h want %h", out_idx, insn_o, words[out_idx]); end
                    emit_cyc[out_idx] = c;
                end else begin
                    tests++; fails++; $display("FAIL stream extra word: got %h want none", insn_o);
                end
                out_idx++;
            end
            if (valid_i === 1'b1 && stall_o === 1'b0) begin
                acc_cyc[in_idx] = c;
                in_idx++;
            end
            step();
        end
        tests++; if (out_idx != 4) begin fails++; $display("FAIL stream out count: got %0d want 4", out_idx); end
        tests++; if (in_idx != 4) begin fails++; $display("FAIL stream in count: got %0d want 4", in_idx); end
        for (int i = 0; i < 4; i++) begin
            tests++; if (acc_cyc[i] != exp_acc[i]) begin fails++; $display("FAIL stream accept W%0d cycle: got %0d want %0d", i, acc_cyc[i], exp_acc[i]); end
            tests++; if (emit_cyc[i] != exp_emit[i]) begin fails++; $display("FAIL stream emit W%0d cycle: got %0d want %0d", i, emit_cyc[i], exp_emit[i]); end
        end
    endtask

    task automatic test_reset_full();
        stall_i = 1'b0;
        drive(1'b1, 7'h20, 1'b0, 5'd1, 5'd0, 4'h0, 32'h0);
        step();
        stall_i = 1'b1;
        drive(1'b1, 7'h20, 1'b0, 5'd2, 5'd0, 4'h0, 32'h0);
        step();
        tests++; if (stall_o !== 1'b1) begin fails++; $display("FAIL rstfull pre stall_o: got %b want 1", stall_o); end
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL rstfull pre valid_o: got %b want 1", valid_o); end
        rst = 1'b1;
        drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
        step();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rstfull valid_o: got %b want 0", valid_o); end
        tests++; if (stall_o !== 1'b0) begin fails++; $display("FAIL rstfull stall_o: got %b want 0", stall_o); end
        tests++; if (insn_o !== 32'h0) begin fails++; $display("FAIL rstfull insn_o: got %h want 00000000", insn_o); end
        rst     = 1'b0;
        stall_i = 1'b0;
        drive(1'b1, 7'h0A, 1'b1, 5'd0, 5'd0, 4'h0, 32'h0000_001F);
        step();
        tests++; if (valid_o !== 1'b1) begin fails++; $display("FAIL rstfull new valid_o: got %b want 1", valid_o); end
        tests++; if (insn_o !== 32'h1500_001F) begin fails++; $display("FAIL rstfull new insn_o: got %h want 1500001f", insn_o); end
        tests++; if (err_o !== 1'b0) begin fails++; $display("FAIL rstfull new err_o: got %b want 0", err_o); end
        drive(1'b0, 7'h00, 1'b0, 5'd0, 5'd0, 4'h0, 32'h0);
        step();
        tests++; if (valid_o !== 1'b0) begin fails++; $display("FAIL rstfull drain valid_o: got %b want 0", valid_o); end
    endtask

    initial begin
        words[0] = 32'h4000_0000;
        words[1] = 32'h4008_0000;
        words[2] = 32'h4010_0000;
        words[3] = 32'h4018_0000;
        test_reset();
        test_pack();
        test_back_to_back();
        test_stall_stream();
        test_reset_full();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
